// File: rtl/acc_dump_ctrl.sv
// acc_dump_ctrl: integrate-and-dump controller for a signed accumulator.
// Counts N_SAMPLES accepted input samples and gates the accumulator clock
// enable while it counts. It then captures the block sum, clears the
// accumulator, and scales, rounds and saturates the sum into a block average.
// Optional feature, selected by the macro ACC_DUMP_ROUND_EN:
//   defined   -> add 2^(SHIFT-1) before the shift (round half up)
//   undefined -> plain arithmetic shift (floor)
//
// Handshakes (both ports): a beat transfers on a cycle where valid and ready
// are both high at posedge clk. Valid never depends on ready. Once valid is
// raised, it and its data stay stable until the beat transfers.
module acc_dump_ctrl #(
    parameter int N_SAMPLES = 16,
    parameter int SHIFT     = 4,
    parameter int IN_W      = 21,
    parameter int OUT_W     = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_ce,
    output logic             acc_clr,
    input  logic [IN_W-1:0]  acc_y,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sat,
    output logic             state_dbg
);

    localparam int CNT_W = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    // One guard bit over the accumulator width.
    // The rounding add therefore cannot wrap.
    localparam int EXT_W = IN_W + 1;

`ifdef ACC_DUMP_ROUND_EN
    // Half of one output LSB. This is zero when SHIFT is 0.
    localparam logic signed [EXT_W-1:0] RND_TERM = EXT_W'((1 << SHIFT) >> 1);
`else
    localparam logic signed [EXT_W-1:0] RND_TERM = '0;
`endif

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ACC  = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dump_fire;

    logic signed [EXT_W-1:0] y_ext;
    logic signed [EXT_W-1:0] y_rnd;
    logic signed [EXT_W-1:0] y_shr;
    logic signed [EXT_W-1:0] y_sat;
    logic                    sat_flag;

    // State register and sample counter; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, sample counting and accumulator control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        acc_ce    = 1'b0;
        dump_fire = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                acc_ce   = in_valid;
                if (in_valid) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DUMP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DUMP: begin
                // acc_y holds the full block sum here.
                // The accumulator is registered, and its last enable was the
                // previous cycle. Dump once the output slot is free or
                // draining this cycle.
                dump_fire = ~out_valid | out_ready;
                if (dump_fire) begin
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
        // Holding the controller in reset also holds the accumulator clear.
        acc_clr = ~rst | dump_fire;
    end

    // Scale, round and saturate the captured block sum.
    always_comb begin
        y_ext    = $signed({acc_y[IN_W-1], acc_y});
        y_rnd    = y_ext + RND_TERM;
        y_shr    = y_rnd >>> SHIFT;
        y_sat    = y_shr;
        sat_flag = 1'b0;
        if (y_shr > SAT_MAX) begin
            y_sat    = SAT_MAX;
            sat_flag = 1'b1;
        end else if (y_shr < SAT_MIN) begin
            y_sat    = SAT_MIN;
            sat_flag = 1'b1;
        end
    end

    // Output register. A new result may replace one that transfers in the
    // same cycle; otherwise a held result stays stable until accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (dump_fire) begin
            out_valid <= 1'b1;
            out_data  <= y_sat[OUT_W-1:0];
            out_sat   <= sat_flag;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign state_dbg = (state == DUMP);

endmodule

// File: doc/acc_dump_ctrl.md
Name: acc_dump_ctrl

Overview:
- Integrate-and-dump controller sitting directly downstream of the 13-bit-in / 21-bit-out signed accumulator.
- Gates the accumulator clock enable from an upstream sample handshake and counts N_SAMPLES accepted samples.
- Captures the accumulator output, clears the accumulator, then scales, rounds and saturates the sum.
- Presents the result as a block average on a valid/ready output port.

Parameters:
- N_SAMPLES, 16, samples per dump; legal range 2..256 (13-bit × 256 fits 21 bits).
- SHIFT, 4, arithmetic right shift applied to the sum; legal range 0..8.
- IN_W, 21, accumulator output width.
- OUT_W, 13, result width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream sample strobe; the sample itself goes straight to the accumulator x input.
- in_ready  out  1  controller accepts a sample this cycle.
- acc_ce  out  1  accumulator clock enable.
- acc_clr  out  1  accumulator reset, active-high.
- acc_y  in  IN_W  signed accumulator output.
- out_data  out  OUT_W  signed scaled block result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  1  out_data was saturated; qualified by out_valid.

Behaviour:
- Reset (rst=0 at a posedge): state=ACC, cnt=0, out_valid=0, out_data=0, out_sat=0.
- acc_clr = ~rst | dump_fire, combinational, so the accumulator is cleared while the controller is held in reset.
- States: ACC, DUMP. cnt width = clog2(N_SAMPLES).

ACC:
- in_ready=1; acc_ce=in_valid; acc_clr=0 (rst high).
- On in_valid: cnt<=cnt+1.
- On in_valid with cnt==N_SAMPLES-1: cnt<=0, state<=DUMP.

DUMP:
- in_ready=0; acc_ce=0.
- acc_y now holds the sum of N_SAMPLES samples, because the accumulator output is registered and the last ce was the previous cycle.
- dump_fire = ~out_valid | out_ready.
- If dump_fire:
  - out_data <= sat(scale(acc_y)).
  - out_sat <= saturation flag.
  - out_valid <= 1.
  - acc_clr = 1; the accumulator is zero on the next cycle.
  - state <= ACC.
- Else remain in DUMP (stall): acc_y is held, no samples are accepted, the accumulator is not cleared.

Output handshake:
- Transfer occurs when out_valid & out_ready.
- out_valid <= 0 on transfer unless dump_fire loads a new result in the same cycle, in which case out_valid stays 1 with new data.
- out_data and out_sat are stable while out_valid=1 and out_ready=0.

Latency and throughput:
- The result appears in the cycle after the DUMP cycle.
- With no backpressure, one DUMP bubble per block: N_SAMPLES+1 cycles per result at full in_valid rate.

Arithmetic:
- Sign-extend acc_y to IN_W+1 bits.
- Apply the rounding term (see Optional Feature), then arithmetic shift right by SHIFT.
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 if clipped.

Boundary conditions:
- in_valid while in DUMP is ignored (in_ready=0); upstream holds the sample.
- Reset mid-block (any state): partial count is discarded, the accumulator is cleared, and any pending out_valid is dropped.

Optional Feature:
- Macro: ACC_DUMP_ROUND_EN.
- Defined: add 2^(SHIFT-1) before the shift, i.e. round-half-up (toward +inf). No rounding term when SHIFT=0.
- Undefined: no rounding term; plain arithmetic shift (floor).

Test Plan:
1. N=16, SHIFT=4, x=100 on 16 consecutive in_valid cycles -> one DUMP cycle with acc_clr=1, then out_valid=1, out_data=100, out_sat=0; acc_y=0 on the following cycle.
2. N=16, SHIFT=4, x=-3 ×16 (sum -48) -> out_data=-3 in both builds.
3. N=16, SHIFT=4, two blocks with sums 24 and -24:
   - With ACC_DUMP_ROUND_EN: out_data=2, then -1.
   - Without: out_data=1, then -2.
4. N=16, SHIFT=0, x=4095 ×16 (sum 65520) -> out_data=4095, out_sat=1.
   - Same with x=-4096 ×16 -> out_data=-4096, out_sat=1.
5. Backpressure: out_ready=0 after block 1 and block 2 completes -> controller holds DUMP with in_ready=0, acc_ce=0, acc_clr=0, out_data=block 1 value.
   - Raise out_ready -> block 1 transfers and block 2 loads in the same cycle.
   - Then in_ready=1 and acc_y=0 on the next cycle.
6. Reset mid-block: rst=0 after 7 samples -> acc_clr=1, out_valid=0.
   - After rst=1, 16 samples of x=10 -> out_data=10, not including the partial block.
